// File: rtl/fp_div_norm_round.sv
// rtl/fp_div_norm_round.sv - single-precision divider normalise/round/range-check stage
//
// Takes the raw quotient of the divider core (sign, provisional biased exponent,
// 27-bit quotient with sticky), normalises it one bit per cycle, rounds it and
// packs an IEEE-754 single with overflow/underflow flags.
//
// Optional feature macro: FP_ROUND_NEAREST_EN
//    defined   : round-to-nearest-even on guard/sticky
//    undefined : truncation (guard and sticky ignored, no mantissa carry-out)
//
// Parameters:
//    MAX_LSHIFT  left-normalisation shifts allowed before the value is taken as zero
//
// Ports:
//    clk, rst             rising-edge clock, asynchronous active-high reset
//    in_valid/in_ready    input handshake (in_ready high only in IDLE)
//    in_sign              result sign
//    in_exp[9:0]          signed biased exponent referred to quotient bit 25
//    in_quo[26:0]         quotient, value = in_quo * 2^-25
//    in_sticky            OR of remainder bits below in_quo[0]
//    out_valid/out_ready  output handshake (result held until accepted)
//    out[31:0]            packed {sign, exp[7:0], frac[22:0]}
//    overflow, underflow  saturated-to-infinity / flushed-to-zero flags

module fp_div_norm_round #(
   parameter int MAX_LSHIFT = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [26:0] in_quo,
   input  logic        in_sticky,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        overflow,
   output logic        underflow
);

   localparam int CW = $clog2(MAX_LSHIFT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NORM  = 2'd1,
      S_ROUND = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_sign;
   logic signed [10:0] r_exp;
   logic [26:0]        r_quo;
   logic               r_sticky;
   logic [CW-1:0]      r_cnt;
   logic               r_zero;
   logic [31:0]        r_out;
   logic               r_ovf;
   logic               r_udf;

   logic               w_norm_zero;
   logic               w_shift_r;
   logic               w_shift_l;

   logic [22:0]        w_frac;
   logic               w_guard;
   logic               w_inc;
   logic [23:0]        w_frac_sum;
   logic signed [10:0] w_exp_fin;
   logic               w_ovf;
   logic               w_udf;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign out       = r_out;
   assign overflow  = r_ovf;
   assign underflow = r_udf;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_norm_zero = 1'b0;
      w_shift_r   = 1'b0;
      w_shift_l   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_state_nxt = S_NORM;
         end
         S_NORM: begin
            if (r_quo == 27'd0) begin
               w_norm_zero = 1'b1;
               w_state_nxt = S_ROUND;
            end else if (r_quo[26]) begin
               // Re-enter NORM after the right shift so the hidden bit is
               // confirmed on the next cycle like any other normalised value.
               w_shift_r   = 1'b1;
            end else if (r_quo[25]) begin
               w_state_nxt = S_ROUND;
            end else if (r_cnt == CW'(MAX_LSHIFT)) begin
               w_norm_zero = 1'b1;
               w_state_nxt = S_ROUND;
            end else begin
               w_shift_l   = 1'b1;
            end
         end
         S_ROUND: begin
            w_state_nxt = S_OUT;
         end
         S_OUT: begin
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------- rounding
   assign w_frac  = r_quo[24:2];
   assign w_guard = r_quo[1];

`ifdef FP_ROUND_NEAREST_EN
   assign w_inc = w_guard & (r_sticky | r_quo[2]);
`else
   assign w_inc = 1'b0;
   logic w_unused_rnd;
   assign w_unused_rnd = ^{w_guard, r_sticky};
`endif

   // Bit 23 of the sum is the mantissa carry-out; the low 23 bits are then
   // already zero, so they can be packed directly.
   assign w_frac_sum = {1'b0, w_frac} + {23'd0, w_inc};
   assign w_exp_fin  = r_exp + $signed({10'd0, w_frac_sum[23]});
   assign w_ovf      = (w_exp_fin >= 11'sd255);
   assign w_udf      = (w_exp_fin <= 11'sd0);

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_quo    <= '0;
         r_sticky <= 1'b0;
         r_cnt    <= '0;
         r_zero   <= 1'b0;
         r_out    <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sign   <= in_sign;
                  r_exp    <= {in_exp[9], in_exp};
                  r_quo    <= in_quo;
                  // The round bit only ever matters as part of the sticky.
                  r_sticky <= in_sticky | in_quo[0];
                  r_cnt    <= '0;
                  r_zero   <= 1'b0;
               end
            end
            S_NORM: begin
               if (w_norm_zero) begin
                  r_zero <= 1'b1;
               end else if (w_shift_r) begin
                  r_quo    <= {1'b0, r_quo[26:1]};
                  r_exp    <= r_exp + 11'sd1;
                  r_sticky <= r_sticky | r_quo[0];
               end else if (w_shift_l) begin
                  r_quo <= {r_quo[25:0], 1'b0};
                  r_exp <= r_exp - 11'sd1;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ROUND: begin
               if (r_zero) begin
                  r_out <= {r_sign, 31'd0};
                  r_ovf <= 1'b0;
                  r_udf <= 1'b0;
               end else if (w_ovf) begin
                  r_out <= {r_sign, 8'hFF, 23'd0};
                  r_ovf <= 1'b1;
                  r_udf <= 1'b0;
               end else if (w_udf) begin
                  r_out <= {r_sign, 31'd0};
                  r_ovf <= 1'b0;
                  r_udf <= 1'b1;
               end else begin
                  r_out <= {r_sign, w_exp_fin[7:0], w_frac_sum[22:0]};
                  r_ovf <= 1'b0;
                  r_udf <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
